// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state type and add/sub flag helper for alu_seq
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_ANDN = 3'd4;
    localparam logic [2:0] OP_ORN  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_SLTU = 3'd7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // top is bit WIDTH of the WIDTH+1-bit sum; for SUB that bit is the borrow.
    function automatic logic [1:0] add_sub_cv(
        input logic is_sub,
        input logic top,
        input logic a_msb,
        input logic b_msb,
        input logic r_msb
    );
        logic v;
        if (is_sub) begin
            v = (a_msb != b_msb) && (r_msb != a_msb);
        end else begin
            v = (a_msb == b_msb) && (r_msb != a_msb);
        end
        return {top, v};
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] P
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] addend;
    logic [CW-1:0]    cnt;

    // The final iteration is folded into P so the product is ready on the done edge.
    assign addend = mplier[0] ? mcand : '0;
    assign P      = acc + addend;
    assign done   = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
        end else if (busy) begin
            acc    <= P;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result, N/Z/C/V flags and iterative MUL
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] F,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             out_valid,
    input  logic             out_ready
);

    import alu_pkg::*;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             load_alu;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_p;

    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [1:0]       cv_add;
    logic [1:0]       cv_sub;
    logic [WIDTH-1:0] alu_f;
    logic             alu_c;
    logic             alu_v;

    // in_ready depends only on state, rst and out_ready so in_valid never loops back.
    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign is_mul    = (S == OP_MUL);
    assign mul_start = accept && is_mul;
    assign load_alu  = accept && !is_mul;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .A     (A),
        .B     (B),
        .busy  (mul_busy),
        .done  (mul_done),
        .P     (mul_p)
    );

    assign sum_add = {1'b0, A} + {1'b0, B};
    assign sum_sub = {1'b0, A} - {1'b0, B};
    assign cv_add  = add_sub_cv(1'b0, sum_add[WIDTH], A[WIDTH-1], B[WIDTH-1], sum_add[WIDTH-1]);
    assign cv_sub  = add_sub_cv(1'b1, sum_sub[WIDTH], A[WIDTH-1], B[WIDTH-1], sum_sub[WIDTH-1]);

    always_comb begin
        alu_f = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (S)
            OP_AND:  alu_f = A & B;
            OP_OR:   alu_f = A | B;
            OP_ADD: begin
                alu_f          = sum_add[WIDTH-1:0];
                {alu_c, alu_v} = cv_add;
            end
            OP_ANDN: alu_f = A & ~B;
            OP_ORN:  alu_f = A | ~B;
            OP_SUB: begin
                alu_f          = sum_sub[WIDTH-1:0];
                {alu_c, alu_v} = cv_sub;
            end
            OP_SLTU: alu_f = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH]};
            default: alu_f = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul) state_next = BUSY;
                    else        state_next = DONE;
                end
            end
            BUSY: begin
                if (!mul_busy)     state_next = IDLE;
                else if (mul_done) state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (!accept)     state_next = IDLE;
                    else if (is_mul) state_next = BUSY;
                    else             state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            F         <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
        end else begin
            out_valid <= (state_next == DONE);
            if (load_alu) begin
                F <= alu_f;
                Z <= (alu_f == '0);
                N <= alu_f[WIDTH-1];
                C <= alu_c;
                V <= alu_v;
            end else if ((state == BUSY) && mul_done) begin
                F <= mul_p;
                Z <= (mul_p == '0);
                N <= mul_p[WIDTH-1];
                C <= 1'b0;
                V <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH=16
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   S;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] F;
    logic         Z;
    logic         N;
    logic         C;
    logic         V;
    logic         out_valid;
    logic         out_ready;

    typedef struct packed {
        logic [W-1:0] f;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .S         (S),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F         (F),
        .Z         (Z),
        .N         (N),
        .C         (C),
        .V         (V),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint ua;
        longint ub;
        longint sa;
        longint sbv;
        longint r;
        e   = '0;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            3'd0: e.f = a & b;
            3'd1: e.f = a | b;
            3'd2: begin
                r   = ua + ub;
                e.f = r[W-1:0];
                e.c = (r > 65535);
                e.v = ((sa + sbv) > 32767) || ((sa + sbv) < -32768);
            end
            3'd3: begin
                r   = ua * ub;
                e.f = r[W-1:0];
            end
            3'd4: e.f = a & ~b;
            3'd5: e.f = a | ~b;
            3'd6: begin
                r   = ua - ub;
                e.f = r[W-1:0];
                e.c = (ua < ub);
                e.v = ((sa - sbv) > 32767) || ((sa - sbv) < -32768);
            end
            default: e.f = (ua < ub) ? 16'd1 : 16'd0;
        endcase
        e.z = (e.f == '0);
        e.n = e.f[W-1];
        return e;
    endfunction

    // Drive one operation at a negedge, let it be accepted, return at the next negedge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        S        = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        S         = 3'd0;
        A         = '0;
        B         = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({F, Z, N, C, V, out_valid, in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got F=%h ZNCV=%b%b%b%b ov=%b ir=%b want all 0", F, Z, N, C, V, out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_add_sub;
        exp_t e;
        logic [2:0]   ops [4] = '{3'd2, 3'd6, 3'd6, 3'd2};
        logic [W-1:0] as  [4] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF};
        logic [W-1:0] bs  [4] = '{16'h0001, 16'h0001, 16'h0002, 16'h0001};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            e = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 || {F, Z, N, C, V} !== {e.f, e.z, e.n, e.c, e.v}) begin
                bad++;
                $display("FAIL add_sub[%0d]: got ov=%b F=%h ZNCV=%b%b%b%b want ov=1 F=%h ZNCV=%b%b%b%b",
                         i, out_valid, F, Z, N, C, V, e.f, e.z, e.n, e.c, e.v);
            end
        end
        total++;
        if (F !== 16'h8000 || V !== 1'b1) begin
            bad++;
            $display("FAIL add_overflow: got F=%h V=%b want F=8000 V=1", F, V);
        end
    endtask

    task automatic test_mul;
        exp_t e;
        int   viol;
        logic [W-1:0] as [2] = '{16'h00FF, 16'h1234};
        logic [W-1:0] bs [2] = '{16'h0101, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            issue(3'd3, as[i], bs[i]);
            viol = 0;
            for (int j = 0; j < W; j++) begin
                if (in_ready !== 1'b0 || out_valid !== 1'b0) viol++;
                @(negedge clk);
            end
            total++;
            if (viol != 0) begin
                bad++;
                $display("FAIL mul_busy_window[%0d]: got %0d cycles with in_ready/out_valid high want 0", i, viol);
            end
            e = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 || {F, Z, N, C, V} !== {e.f, e.z, e.n, e.c, e.v}) begin
                bad++;
                $display("FAIL mul_result[%0d]: got ov=%b F=%h ZNCV=%b%b%b%b want ov=1 F=%h ZNCV=%b%b%b%b",
                         i, out_valid, F, Z, N, C, V, e.f, e.z, e.n, e.c, e.v);
            end
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   viol;
        @(negedge clk);
        out_ready = 1'b0;
        issue(3'd1, 16'h00F0, 16'h0F00);
        S        = 3'd7;
        A        = 16'h0001;
        B        = 16'hFFFF;
        in_valid = 1'b1;
        viol     = 0;
        for (int j = 0; j < 5; j++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || F !== sb[0].f) viol++;
            @(negedge clk);
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL backpressure_hold: got %0d bad hold cycles want 0", viol);
        end
        e = sb.pop_front();
        total++;
        if ({F, Z, N, C, V} !== {e.f, e.z, e.n, e.c, e.v}) begin
            bad++;
            $display("FAIL backpressure_or: got F=%h want F=%h", F, e.f);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL done_in_ready: got %b want 1", in_ready);
        end
        sb.push_back(model(3'd7, 16'h0001, 16'hFFFF));
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || {F, Z, N, C, V} !== {e.f, e.z, e.n, e.c, e.v}) begin
            bad++;
            $display("FAIL backpressure_sltu: got ov=%b F=%h want ov=1 F=%h", out_valid, F, e.f);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [2:0] ops [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
                end
            end
            S        = ops[i % 7];
            A        = W'($urandom);
            B        = W'($urandom);
            in_valid = 1'b1;
            sb.push_back(model(S, A, B));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 || {F, Z, N, C, V} !== {e.f, e.z, e.n, e.c, e.v}) begin
                bad++;
                $display("FAIL b2b[%0d]: got ov=%b F=%h ZNCV=%b%b%b%b want ov=1 F=%h ZNCV=%b%b%b%b",
                         i, out_valid, F, Z, N, C, V, e.f, e.z, e.n, e.c, e.v);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mul;
        exp_t e;
        int   stray;
        int   n;
        @(negedge clk);
        out_ready = 1'b1;
        issue(3'd3, 16'h1234, 16'h5678);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        #1;
        total++;
        if ({F, Z, N, C, V, out_valid} !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_mul: got F=%h ZNCV=%b%b%b%b ov=%b ir=%b want 0 and ir=1", F, Z, N, C, V, out_valid, in_ready);
        end
        @(negedge clk);
        issue(3'd4, 16'hFFFF, 16'h00FF);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        total++;
        if (n >= 40 || {F, Z, N, C, V} !== {e.f, e.z, e.n, e.c, e.v}) begin
            bad++;
            $display("FAIL andn_after_rst: got ov=%b F=%h want ov=1 F=%h", out_valid, F, e.f);
        end
        @(negedge clk);
        stray = 0;
        for (int j = 0; j < 20; j++) begin
            if (out_valid !== 1'b0) stray++;
            @(negedge clk);
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL no_stray_result: got %0d cycles with out_valid want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 16-bit combinational ALU. The block keeps the 3-bit operation encoding, generalises operand width, and adds the following:
- registered results;
- a full N/Z/C/V flag set;
- an iterative multi-cycle multiply on the previously unused opcode 3;
- valid/ready flow control on both input and output.

It sits between the datapath operand latches and the writeback stage.

## Interface
- WIDTH, 16 — operand/result width in bits; legal values are 4 to 64.
- clk  in  1 — clock; everything is on the rising edge.
- rst  in  1 — reset, synchronous, active-high.
- S  in  3 — operation select.
- A  in  WIDTH — operand A.
- B  in  WIDTH — operand B.
- in_valid  in  1 — S/A/B valid.
- in_ready  out  1 — block accepts an operation this cycle.
- F  out  WIDTH — result.
- Z  out  1 — zero flag, F == 0.
- N  out  1 — negative flag, F[WIDTH-1].
- C  out  1 — carry/borrow flag.
- V  out  1 — signed overflow flag.
- out_valid  out  1 — F and flags valid.
- out_ready  in  1 — consumer takes the result.

## Operation
- Accept: an operation is accepted when in_valid && in_ready on a rising edge. S/A/B are captured at accept and are don't-care afterwards.
- Opcodes:

| S | Operation | F |
|---|-----------|---|
| 0 | AND | A&B |
| 1 | OR | A\|B |
| 2 | ADD | A+B |
| 3 | MUL | low WIDTH bits of A*B, unsigned |
| 4 | ANDN | A&~B |
| 5 | ORN | A\|~B |
| 6 | SUB | A-B |
| 7 | SLTU | {0…,A<B} unsigned |

- Arithmetic: all arithmetic is modulo 2^WIDTH, computed in WIDTH+1 bits.
- C flag:
  - ADD: carry out.
  - SUB: borrow, i.e. 1 when A<B unsigned.
  - All other ops: 0.
- V flag:
  - ADD/SUB: two's-complement overflow.
  - All other ops: 0.
- Z and N are derived from the final F for every op, MUL included.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: MUL in progress; in_ready=0, out_valid=0.
  - DONE: out_valid=1; F and flags are held stable.
- Transitions:
  - IDLE → DONE: accept of any non-MUL op.
  - IDLE → BUSY: accept of MUL.
  - BUSY → DONE: after WIDTH iterations.
  - DONE → IDLE: out_ready && !in_valid.
  - DONE → DONE or BUSY: out_ready && in_valid. This is a back-to-back accept in the same cycle; in_ready = out_ready while in DONE.
- DONE with out_ready=0: F, flags and out_valid hold, and in_ready=0.
- MUL algorithm: shift-add, one multiplier bit per cycle, LSB first. There is no early termination, including for B=0.

## Timing
- Reset: F=0, Z=0, N=0, C=0, V=0, out_valid=0, and state=IDLE. in_ready is 0 in any cycle where rst=1.
- Reset mid-operation: reset aborts BUSY or DONE immediately. No result is emitted and the pending operation is discarded.
- Latency, single-cycle ops: accept at edge k gives out_valid=1 after edge k (one cycle).
- Latency, MUL: accept at edge k gives out_valid=1 after edge k+WIDTH (WIDTH cycles).
- Throughput, single-cycle ops: 1 op/cycle with out_ready held high.
- Throughput, MUL: 1 op per WIDTH cycles.
- Outputs: F/flags/out_valid come straight from registers. in_ready is a combinational function of state, rst and out_ready only, so there is no path from in_valid to in_ready.
- Stability: F and flags change only on the edge that moves the block into DONE.

## Structure
- Package alu_pkg:
  - opcode constants OP_AND…OP_SLTU (3'd0–3'd7);
  - state enum {IDLE, BUSY, DONE};
  - a function computing {C,V} for add/sub given WIDTH+1-bit sums.
- Sub-module alu_mul_iter (WIDTH):
  - ports start, A, B, busy, done, P[WIDTH-1:0];
  - contains the shift-add accumulator and iteration counter.
- alu_seq owns the FSM, single-cycle datapath, flag logic and output registers.

## Test plan
All scenarios use WIDTH=16.
- ADD 0xFFFF+0x0001, out_ready=1: one cycle later F=0x0000, Z=1, C=1, V=0, N=0.
- SUB 0x8000-0x0001: F=0x7FFF, V=1, C=0, N=0. SUB 0x0001-0x0002: F=0xFFFF, C=1, N=1, V=0.
- MUL 0x00FF*0x0101 (one-cycle in_valid pulse):
  - in_ready=0 for 16 cycles;
  - out_valid rises exactly 16 cycles after accept with F=0xFFFF, N=1, C=0, V=0.
  - MUL 0x1234*0x0000 gives F=0, Z=1, still after 16 cycles.
- Backpressure:
  - complete OR 0x00F0|0x0F00 with out_ready=0 for 5 cycles: F=0x0FF0 stable, out_valid=1, in_ready=0 throughout.
  - Then raise out_ready with in_valid/SLTU 0x0001,0xFFFF present: next cycle F=0x0001.
  - Check 8 back-to-back single-cycle ops complete at 1/cycle.
- Reset mid-MUL: assert rst for 1 cycle, 5 cycles into a MUL. Next cycle all outputs are at reset values and state=IDLE; a subsequent ANDN 0xFFFF,0x00FF gives F=0xFF00.
